// File: rtl/data_mem_ctrl.sv
`timescale 1ns/1ps
// data_mem_ctrl
//   Multi-cycle data memory controller for a simple in-order pipeline.
//   Each load or store is accepted only from IDLE. The controller stalls the
//   pipeline for WAIT_CYCLES+1 cycles, performs the word access, and then
//   spends one DONE cycle pulsing done. A rejected request does not wait: it
//   stalls for one cycle and then pulses done together with err.
//
// Parameters
//   DEPTH        number of 32-bit words in the internal memory
//   WAIT_CYCLES  wait states per access (legal range 1..15)
//
// Ports
//   clk                clock; all state updates on the rising edge
//   rst                synchronous active-high reset
//   control_mem_read   load request from the decoder
//   control_mem_write  store request from the decoder
//   addr               byte address from the ALU
//   wdata              store data
//   rdata              registered load result
//   stall              hold the pipeline while high
//   done               one-cycle pulse marking access completion
//   err                one-cycle pulse with done when a request was rejected
module data_mem_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        control_mem_read,
  input  logic        control_mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            err_q;
  logic [AW-1:0]   word_q;
  logic [31:0]     wdata_q;
  logic            wr_q;
  logic [31:0]     mem [DEPTH];

  logic            req;
  logic            req_ok;
  logic            access;

  // A request is valid only with exactly one operation, a word-aligned
  // address, and a word index that falls inside the memory.
  assign req    = control_mem_read | control_mem_write;
  assign req_ok = (control_mem_read ^ control_mem_write) &&
                  (addr[1:0] == 2'b00) &&
                  ({2'b00, addr[31:2]} < DEPTH_W);

  // The access itself happens on the edge that leaves the last wait state.
  assign access = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall     = 1'b1;
          state_nxt = req_ok ? WAIT : DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Requests seen here belong to the instruction completing now.
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        err_q <= ~req_ok;
        cnt   <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Request operands: captured once per accepted request, never reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_ok) begin
      word_q  <= addr[AW+1:2];
      wdata_q <= wdata;
      wr_q    <= control_mem_write;
    end
  end

  // Memory array: not cleared by reset; a reset on the access edge aborts
  // a pending store.
  always_ff @(posedge clk) begin
    if (!rst && access && wr_q) begin
      mem[word_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (access && !wr_q) begin
      rdata <= mem[word_q];
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in the internal data memory.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states per access; the legal range is 1..15.
REQ-003 SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port control_mem_read, input, 1 bit: load request from the decoder.
REQ-007 SHALL have port control_mem_write, input, 1 bit: store request from the decoder.
REQ-008 SHALL have port addr, input, 32 bits: byte address from the ALU.
REQ-009 SHALL have port wdata, input, 32 bits: store data.
REQ-010 SHALL have port rdata, output, 32 bits: load result, registered.
REQ-011 SHALL have port stall, output, 1 bit: hold the pipeline while high.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking access completion.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse with done when a request was rejected.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and DONE, plus a 4-bit wait counter.
REQ-015 In IDLE, a request (read or write high) SHALL drive stall=1 combinationally in that same cycle.
REQ-016 A valid request SHALL latch addr, wdata and the operation on the clock edge, load the counter with WAIT_CYCLES-1, and go to WAIT.
REQ-017 A request is valid only when:
- exactly one of read/write is high;
- addr[1:0]==0;
- word index addr>>2 < DEPTH.
REQ-018 In WAIT, stall SHALL be 1.
- The counter SHALL decrement each cycle.
- When the counter is 0, the access SHALL be performed on the clock edge and the FSM SHALL go to DONE.
- A write stores the latched wdata at the latched word; a read loads that word into rdata.
REQ-019 In DONE: stall=0, done=1, err=0.
- rdata SHALL hold the loaded word for a read and keep its prior value for a write.
- The next state SHALL be IDLE unconditionally.
REQ-020 Request inputs SHALL be ignored in DONE; they belong to the instruction completing that cycle.
REQ-021 Total stall cycles for a valid access SHALL be WAIT_CYCLES+1; done SHALL assert WAIT_CYCLES+1 cycles after the request cycle.
REQ-022 An invalid request SHALL be handled as follows:
- stall=1 in the request cycle, then go directly to DONE;
- in DONE, err=1 and done=1;
- no memory change, and rdata unchanged.
REQ-023 With no request in IDLE: stall=0, done=0, err=0, and the FSM SHALL stay in IDLE.
REQ-024 Back-to-back requests SHALL each be accepted only from IDLE, so at least one DONE cycle separates accesses.
REQ-025 Memory contents SHALL be 32-bit words indexed by addr[log2(DEPTH)+1:2], with no byte enables (word access only).

Reset
REQ-026 With rst high on a rising edge:
- state SHALL go to IDLE, counter to 0, rdata to 0;
- done=0, err=0, and stall SHALL be forced to 0 while rst is high.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset during WAIT SHALL abort the pending access: a pending write SHALL NOT modify memory, and no done pulse SHALL be produced.

Verification
REQ-029 Store then load:
- write addr=0x10, wdata=0xDEADBEEF with WAIT_CYCLES=2 -> stall high for 3 cycles, done on the 4th cycle;
- then read addr=0x10 -> rdata=0xDEADBEEF with done.
REQ-030 Misaligned read addr=0x12 -> stall for 1 cycle, next cycle done=1 and err=1, rdata unchanged, memory unchanged.
REQ-031 Out-of-range write addr=0x400 (DEPTH=256) -> err=1 and done=1; a read-back of word 0 shows its prior value.
REQ-032 read=1 and write=1 together at addr=0x20 -> err=1; location 0x20 unchanged.
REQ-033 Write 0x12345678 to 0x40, then assert rst in the 2nd WAIT cycle -> no done pulse, and a subsequent read of 0x40 returns the old value.
REQ-034 Read addr=0x10 held high through DONE followed by a new read addr=0x14 -> two separate stall windows, separated by exactly one DONE cycle, with two done pulses.
